// File: rtl/alu_mul_16bit.sv
// Unsigned 16x16 iterative shift-and-add multiplier producing a 32-bit product.
// One 16-bit ripple adder is reused across the 16 RUN steps of each operation.

module alu_add_16bit (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_ci,
   output logic [15:0] o_s,
   output logic        o_co
);

   assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {16'h0000, i_ci};

endmodule

module alu_mul_16bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [31:0] P,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_mcand;
   logic [31:0] r_work;
   logic [4:0]  r_count;
   logic [31:0] r_p;

   logic [15:0] w_addB;
   logic [15:0] w_sum;
   logic        w_carry;
   logic [31:0] w_workNext;

   assign w_addB = r_work[0] ? r_mcand : 16'h0000;

   alu_add_16bit u_add (
      .i_a  (r_work[31:16]),
      .i_b  (w_addB),
      .i_ci (1'b0),
      .o_s  (w_sum),
      .o_co (w_carry)
   );

   // The adder carry becomes the new MSB so the partial product never overflows.
   assign w_workNext = {w_carry, w_sum, r_work[15:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_mcand <= 16'h0000;
         r_work  <= 32'h0000_0000;
         r_count <= 5'd0;
         r_p     <= 32'h0000_0000;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand <= A;
                  r_work  <= {16'h0000, B};
                  r_count <= 5'd0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_work  <= w_workNext;
               r_count <= r_count + 5'd1;
               if (r_count == 5'd15) begin
                  r_p     <= w_workNext;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign P    = r_p;
   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);

endmodule

// File: tb/tb_alu_mul_16bit.sv
// Directed and random bench for alu_mul_16bit; products are queued at start and
// compared against P whenever done is observed.

module tb_alu_mul_16bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic [31:0] P;
   logic        busy;
   logic        done;

   int          checks;
   int          errors;
   logic [31:0] expQ[$];
   logic [31:0] lastP;

   alu_mul_16bit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Scoreboard side: every done pulse must match the oldest outstanding product.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 32'h1, 32'h0);
         end else begin
            lastP = expQ.pop_front();
            checkOutput("product", P, lastP);
         end
      end
   end

   // Drives one operation from its first IDLE cycle through the done cycle.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit pulseIgnored);
      @(negedge clk);
      checkOutput("idle_busy", {31'h0, busy}, 32'h0);
      checkOutput("idle_done", {31'h0, done}, 32'h0);
      checkOutput("p_hold", P, lastP);
      start = 1'b1;
      A = a;
      B = b;
      expQ.push_back({16'h0000, a} * {16'h0000, b});
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 16'($urandom);
      B = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checkOutput("run_busy", {31'h0, busy}, 32'h1);
         checkOutput("run_done", {31'h0, done}, 32'h0);
         if (pulseIgnored && i == 4) begin
            start = 1'b1;
            A = 16'h0007;
            B = 16'h0007;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      @(negedge clk);
      checkOutput("done_pulse", {31'h0, done}, 32'h1);
      checkOutput("done_busy", {31'h0, busy}, 32'h0);
      @(posedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      lastP  = 32'h0;
      rst    = 1'b1;
      start  = 1'b0;
      A      = 16'h0000;
      B      = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_p", P, 32'h0);
      checkOutput("reset_busy", {31'h0, busy}, 32'h0);
      checkOutput("reset_done", {31'h0, done}, 32'h0);

      applyStimulus(16'h0003, 16'h0005, 1'b0);
      checkOutput("basic_p", lastP, 32'h0000_000F);
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
      checkOutput("max_p", lastP, 32'hFFFE_0001);
      applyStimulus(16'h0000, 16'h1234, 1'b0);
      checkOutput("zero_p", lastP, 32'h0000_0000);
      applyStimulus(16'h1234, 16'h0100, 1'b0);
      checkOutput("shift_p", lastP, 32'h0012_3400);
      applyStimulus(16'h0002, 16'h0003, 1'b1);
      checkOutput("ignored_start_p", lastP, 32'h0000_0006);

      // Abort: reset lands on the edge ending RUN cycle 8.
      @(negedge clk);
      start = 1'b1;
      A = 16'h00FF;
      B = 16'h00FF;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy", {31'h0, busy}, 32'h0);
      checkOutput("abort_done", {31'h0, done}, 32'h0);
      checkOutput("abort_p", P, 32'h0);
      lastP = 32'h0;
      repeat (20) @(negedge clk);
      checkOutput("abort_quiet_busy", {31'h0, busy}, 32'h0);
      checkOutput("abort_quiet_p", P, 32'h0);

      // Reset wins over a simultaneous start.
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      A = 16'h0009;
      B = 16'h0009;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checkOutput("rst_prio_busy", {31'h0, busy}, 32'h0);
      @(posedge clk);

      for (int n = 0; n < 1000; n++) begin
         applyStimulus(16'($urandom), 16'($urandom), 1'b0);
      end

      @(negedge clk);
      checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
